// File: rtl/antirrebote_pkg.sv
// Shared types and defaults for the push-button/switch input conditioner.
// FSM encoding and timing constants used by antirrebote and its bench.
package antirrebote_pkg;

    typedef enum logic [1:0] {
        ESTABLE_BAJO   = 2'b00,
        VALIDANDO_ALTO = 2'b01,
        ESTABLE_ALTO   = 2'b11,
        VALIDANDO_BAJO = 2'b10
    } estado_t;

    localparam int CICLOS_DEF = 1000000;
    localparam int ETAPAS_DEF = 2;
    localparam int CICLOS_SIM = 8;

endpackage

// File: rtl/sincronizador.sv
// N-stage flip-flop synchronizer for one asynchronous pin.
// Only the first stage may go metastable; q is the last stage.
module sincronizador #(
    parameter int ETAPAS_SINC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [ETAPAS_SINC-1:0] r_ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ff <= '0;
        end else begin
            r_ff <= {r_ff[ETAPAS_SINC-2:0], d};
        end
    end

    assign q = r_ff[ETAPAS_SINC-1];

endmodule

// File: rtl/antirrebote.sv
// Synchronizing debouncer for one board input; optional edge pulses
// are enabled by defining ANTIRREBOTE_PULSOS_EN.
module antirrebote
    import antirrebote_pkg::*;
#(
    parameter int CICLOS_ESTABLES = CICLOS_DEF,
    parameter int ETAPAS_SINC     = ETAPAS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
`ifdef ANTIRREBOTE_PULSOS_EN
    output logic validando,
    output logic pulso_sube,
    output logic pulso_baja
`else
    output logic validando
`endif
);

    localparam int W = $clog2(CICLOS_ESTABLES) + 1;
    localparam logic [W-1:0] TERM = W'(CICLOS_ESTABLES - 1);
    localparam logic [W-1:0] UNO  = W'(1);

    logic          w_s;
    estado_t       r_estado;
    estado_t       w_estado_sig;
    logic [W-1:0]  r_cnt;
    logic [W-1:0]  w_cnt_sig;
    logic          r_out;
    logic          w_out_sig;
    logic          r_validando;
    logic          w_validando_sig;

    sincronizador #(
        .ETAPAS_SINC(ETAPAS_SINC)
    ) u_sinc (
        .clk(clk),
        .rst(rst),
        .d  (in),
        .q  (w_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado    <= ESTABLE_BAJO;
            r_cnt       <= '0;
            r_out       <= 1'b0;
            r_validando <= 1'b0;
        end else begin
            r_estado    <= w_estado_sig;
            r_cnt       <= w_cnt_sig;
            r_out       <= w_out_sig;
            r_validando <= w_validando_sig;
        end
    end

    // Terminal count needs s at the new level, so it never races a reversal.
    always_comb begin
        w_estado_sig = r_estado;
        w_cnt_sig    = r_cnt;
        w_out_sig    = r_out;
        unique case (r_estado)
            ESTABLE_BAJO: begin
                if (w_s) begin
                    w_estado_sig = VALIDANDO_ALTO;
                    w_cnt_sig    = UNO;
                end else begin
                    w_cnt_sig = '0;
                end
            end
            VALIDANDO_ALTO: begin
                if (!w_s) begin
                    w_estado_sig = ESTABLE_BAJO;
                    w_cnt_sig    = '0;
                end else if (r_cnt == TERM) begin
                    w_estado_sig = ESTABLE_ALTO;
                    w_out_sig    = 1'b1;
                    w_cnt_sig    = '0;
                end else begin
                    w_cnt_sig = r_cnt + UNO;
                end
            end
            ESTABLE_ALTO: begin
                if (!w_s) begin
                    w_estado_sig = VALIDANDO_BAJO;
                    w_cnt_sig    = UNO;
                end else begin
                    w_cnt_sig = '0;
                end
            end
            VALIDANDO_BAJO: begin
                if (w_s) begin
                    w_estado_sig = ESTABLE_ALTO;
                    w_cnt_sig    = '0;
                end else if (r_cnt == TERM) begin
                    w_estado_sig = ESTABLE_BAJO;
                    w_out_sig    = 1'b0;
                    w_cnt_sig    = '0;
                end else begin
                    w_cnt_sig = r_cnt + UNO;
                end
            end
            default: begin
                w_estado_sig = ESTABLE_BAJO;
                w_cnt_sig    = '0;
                w_out_sig    = 1'b0;
            end
        endcase
        w_validando_sig = (w_estado_sig == VALIDANDO_ALTO) ||
                          (w_estado_sig == VALIDANDO_BAJO);
    end

    assign out       = r_out;
    assign validando = r_validando;

`ifdef ANTIRREBOTE_PULSOS_EN
    logic r_out_q;
    logic r_pulso_sube;
    logic r_pulso_baja;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_q      <= 1'b0;
            r_pulso_sube <= 1'b0;
            r_pulso_baja <= 1'b0;
        end else begin
            r_out_q      <= r_out;
            r_pulso_sube <= r_out & ~r_out_q;
            r_pulso_baja <= ~r_out & r_out_q;
        end
    end

    assign pulso_sube = r_pulso_sube;
    assign pulso_baja = r_pulso_baja;
`endif

endmodule

// File: doc/antirrebote.md
Name: antirrebote

Overview:
- Input conditioning stage for Nexys A7 push-buttons and slide switches.
- Synchronizes a raw asynchronous pin to clk and removes contact bounce.
- Drives a clean, single-transition level into the downstream combinational logic stages (gates, inverters).
- One instance per physical input.

Parameters:
- CICLOS_ESTABLES, 1000000, consecutive stable synchronized samples required to accept a new level (10 ms at 100 MHz); legal range ≥2.
- ETAPAS_SINC, 2, synchronizer flip-flop depth; legal range ≥2.

Ports:
- clk  input  1  system clock, 100 MHz board oscillator
- rst  input  1  asynchronous, active-high reset
- in  input  1  raw pin level, asynchronous, may bounce
- out  output  1  debounced, synchronized level
- validando  output  1  high while a candidate level change is being timed

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst. On rst: all synchronizer FFs = 0, counter = 0, FSM = ESTABLE_BAJO, out = 0, validando = 0.
- Synchronizer: ETAPAS_SINC-deep FF chain on in, producing s. No other logic reads in directly.
- Counter width: $clog2(CICLOS_ESTABLES)+1 bits, unsigned. It never wraps: it saturates or is cleared before reaching 2^width.
- FSM states: ESTABLE_BAJO, VALIDANDO_ALTO, ESTABLE_ALTO, VALIDANDO_BAJO.
- ESTABLE_BAJO:
  - s=1 → VALIDANDO_ALTO, cnt=1.
  - Otherwise hold, cnt=0.
- VALIDANDO_ALTO:
  - s=0 → ESTABLE_BAJO, cnt=0 (bounce rejected, out unchanged).
  - s=1 and cnt=CICLOS_ESTABLES-1 → ESTABLE_ALTO, out=1, cnt=0.
  - Otherwise cnt+1.
- ESTABLE_ALTO and VALIDANDO_BAJO: mirror image of the two states above, with s and out polarity swapped.
- Outputs: out and validando are registered; validando = 1 in both VALIDANDO states.
- Latency: let edge k be the first clk edge that samples the new level of in. If in holds, out changes at edge k + ETAPAS_SINC - 1 + CICLOS_ESTABLES (9 edges for 2/8).
- Glitch rejection: any excursion of s shorter than CICLOS_ESTABLES samples produces no change on out. The counter restarts from 1 on the next excursion.
- Simultaneous events: rst dominates everything. Counter terminal count and a reversal of s can never coincide, because terminal count requires s to be at the new level on that same edge.
- Reset mid-validation: validation is abandoned and out = 0 immediately (asynchronous), even if out was 1.
- Metastability: only the first synchronizer FF may go metastable. out is glitch-free.

Optional Feature:
- Macro: ANTIRREBOTE_PULSOS_EN.
- Defined:
  - Adds outputs pulso_sube and pulso_baja, each 1 bit, registered, reset 0.
  - Each is high for exactly one clk cycle, on the cycle after out rises or falls respectively.
  - Never both high at the same time.
- Undefined: these ports and their logic do not exist. The port list is exactly as given under Ports.

Decomposition:
- Package antirrebote_pkg:
  - FSM state encoding constants (2-bit: 00 ESTABLE_BAJO, 01 VALIDANDO_ALTO, 11 ESTABLE_ALTO, 10 VALIDANDO_BAJO).
  - Default CICLOS_ESTABLES and ETAPAS_SINC values.
  - Simulation value CICLOS_SIM = 8.
- Sub-module sincronizador:
  - Parameter ETAPAS_SINC; ports clk, rst, d, q.
  - Reused by other pin-input stages.

Test Plan (CICLOS_ESTABLES=8, ETAPAS_SINC=2):
- Reset: assert rst with in=1 → out=0 and validando=0 asynchronously, before any clk edge; after release, out=1 at the 9th edge.
- Clean press: in 0→1 held → validando=1 from the 2nd edge; out=1 exactly at edge k+9, validando=0 at the same edge.
- Bounce: in toggles 1,0,1,0 every 3 cycles, then holds 1 → no out change during toggling; out=1 at 9 edges after the final 0→1.
- Release: from out=1, in 1→0 held → out=0 at edge k+9; a 7-cycle low glitch instead → out stays 1.
- Mid-validation reset: rst pulsed at the 5th cycle of VALIDANDO_ALTO → FSM=ESTABLE_BAJO, cnt=0, out=0; validation restarts after release.
- With ANTIRREBOTE_PULSOS_EN: clean press then release → exactly one pulso_sube cycle and one pulso_baja cycle, each on the cycle after the out edge.
